multicycle_control: RTL

Multi-cycle sequencing FSM for the processor datapath. It replaces the single-cycle opcode decoder with a Moore state machine that steps each instruction through fetch, decode, execute, memory and write-back, driving the datapath enables and mux selects. It stalls on a shared-memory ready handshake, traps on unknown opcodes, and counts retired instructions.

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/multicycle_control.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared encodings for the multi-cycle processor control path
//                (FSM states, opcodes, ALU operation and operand-B selects).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB_ALU = 4'd8,
    S_WB_MEM = 4'd9,
    S_BRANCH = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
//  Module      : multicycle_control
//  Description : Moore sequencing FSM stepping instructions through
//                fetch/decode/execute/memory/write-back, with retire counter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_control
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             PCSource,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  state_t           r_state;
  state_t           w_next;
  logic             w_retire;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_RESET;
    else       r_state <= w_next;
  end

  assign w_retire = (r_state == S_WB_ALU) || (r_state == S_WB_MEM) ||
                    (r_state == S_BRANCH) || ((r_state == S_MEM_WR) && mem_ready);

  always_ff @(posedge clk) begin
    if (reset)         r_count <= '0;
    else if (w_retire) r_count <= r_count + 1'b1;
  end

  always_comb begin
    w_next = S_TRAP;
    case (r_state)
      S_RESET:  w_next = S_FETCH;
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:          w_next = S_EXEC_R;
          OP_ITYPE:          w_next = S_EXEC_I;
          OP_LOAD, OP_STORE: w_next = S_ADDR;
          OP_BRANCH:         w_next = S_BRANCH;
          default:           w_next = S_TRAP;
        endcase
      end
      S_EXEC_R: w_next = S_WB_ALU;
      S_EXEC_I: w_next = S_WB_ALU;
      S_ADDR:   w_next = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: w_next = mem_ready ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR: w_next = mem_ready ? S_FETCH : S_MEM_WR;
      S_WB_ALU: w_next = S_FETCH;
      S_WB_MEM: w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_TRAP;  // encodings 12-15 are never legitimately reached
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALUOP_ADD;
    PCSource    = 1'b0;
    illegal     = 1'b0;
    case (r_state)
      S_FETCH: begin
        // IR and PC load only on the cycle the fetch read completes
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = SRCB_IMM_SH;
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
      end
      S_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_WB_ALU: RegWrite = 1'b1;
      S_WB_MEM: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
      end
      S_TRAP:   illegal = 1'b1;
      default:  ;
    endcase
  end

  assign state       = r_state;
  assign instr_count = r_count;

endmodule

`default_nettype wire
